// File: rtl/redirect_controller_if.sv
// Redirect controller bus.
// Groups the fetch-redirect, syscall and debug signals between the pipeline
// (master) and redirect_controller (slave).
//   Pipeline -> controller : STALL, pred_take/pred_addr, mis_req/mis_addr,
//                            sys_req, sys_ack, cnt_preload/cnt_preload_val
//   Controller -> pipeline : Request_Alt_PC, Alt_PC, FLUSH, fetch_hold, SYS,
//                            mispredict_count, state
// Handshake: these are level requests, not valid/ready pairs. A request is
// taken on the rising CLK edge where it is high and the controller is able to
// accept it (RUN, and STALL=0 for ID-originated requests). Nothing is queued:
// a request that is not taken is dropped, and a held request is taken at the
// first edge that can accept it. sys_ack is taken only while in SYSWAIT.
interface redirect_controller_if;
  logic        STALL;
  logic        pred_take;
  logic [31:0] pred_addr;
  logic        mis_req;
  logic [31:0] mis_addr;
  logic        sys_req;
  logic        sys_ack;
  logic        cnt_preload;      // debug: load mispredict_count from cnt_preload_val
  logic [15:0] cnt_preload_val;
  logic        Request_Alt_PC;
  logic [31:0] Alt_PC;
  logic        FLUSH;
  logic        fetch_hold;
  logic        SYS;
  logic [15:0] mispredict_count;
  logic [1:0]  state;

  modport master (
    output STALL, pred_take, pred_addr, mis_req, mis_addr, sys_req, sys_ack,
           cnt_preload, cnt_preload_val,
    input  Request_Alt_PC, Alt_PC, FLUSH, fetch_hold, SYS, mispredict_count, state
  );

  modport slave (
    input  STALL, pred_take, pred_addr, mis_req, mis_addr, sys_req, sys_ack,
           cnt_preload, cnt_preload_val,
    output Request_Alt_PC, Alt_PC, FLUSH, fetch_hold, SYS, mispredict_count, state
  );
endinterface

// File: rtl/redirect_controller.sv
// Fetch redirect / syscall drain controller.
// Turns predictor and ID-stage requests into a registered PC redirect for IF,
// suppresses wrong-path fetch for FLUSH_DEPTH cycles after a misprediction,
// and drains the back end for DRAIN_CYCLES before handing a syscall over.
// Ports:
//   CLK   - clock, rising edge
//   RESET - asynchronous active-low reset
//   bus   - redirect_controller_if.slave (requests in, redirect/status out)
// Every output comes straight from a flop: one cycle from sampled input.
module redirect_controller #(
  parameter int FLUSH_DEPTH  = 7,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  redirect_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_SYSWAIT = 2'd3
  } state_e;

  // Counters count down to 0 inclusive, so load N-1 to spend N cycles.
  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_DEPTH - 1);
  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  ctr_q, ctr_d;
  logic        req_q, req_d;
  logic [31:0] alt_q, alt_d;
  logic        flush_q, flush_d;
  logic        hold_q, hold_d;
  logic        sys_q, sys_d;
  logic [15:0] cnt_q, cnt_d;

  logic take_mis, take_sys, take_pred;

  // mis_req beats sys_req beats pred_take; STALL gates only the ID requests.
  assign take_mis  = (state_q == ST_RUN) && !bus.STALL && bus.mis_req;
  assign take_sys  = (state_q == ST_RUN) && !bus.STALL && bus.sys_req && !bus.mis_req;
  assign take_pred = (state_q == ST_RUN) && bus.pred_take && !take_mis && !take_sys;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_RUN;
      ctr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      ST_RUN: begin
        if (take_mis) begin
          state_d = ST_FLUSH;
          ctr_d   = FLUSH_LOAD;
        end else if (take_sys) begin
          state_d = ST_DRAIN;
          ctr_d   = DRAIN_LOAD;
        end
      end
      ST_FLUSH: begin
        if (ctr_q == 8'd0) state_d = ST_RUN;
        else               ctr_d   = ctr_q - 8'd1;
      end
      ST_DRAIN: begin
        if (ctr_q == 8'd0) state_d = ST_SYSWAIT;
        else               ctr_d   = ctr_q - 8'd1;
      end
      ST_SYSWAIT: begin
        if (bus.sys_ack) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic: next values of the output flops
  always_comb begin
    req_d   = take_mis || take_pred;
    alt_d   = alt_q;
    if (take_mis)       alt_d = bus.mis_addr;
    else if (take_pred) alt_d = bus.pred_addr;
    flush_d = take_mis;
    // Decoded from the next state so the flags line up with the state output.
    hold_d  = (state_d == ST_DRAIN) || (state_d == ST_SYSWAIT);
    sys_d   = (state_d == ST_SYSWAIT);
    cnt_d   = cnt_q;
    if (bus.cnt_preload)                   cnt_d = bus.cnt_preload_val;
    else if (take_mis && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      req_q   <= 1'b0;
      alt_q   <= 32'h0000_0000;
      flush_q <= 1'b0;
      hold_q  <= 1'b0;
      sys_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      req_q   <= req_d;
      alt_q   <= alt_d;
      flush_q <= flush_d;
      hold_q  <= hold_d;
      sys_q   <= sys_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Request_Alt_PC   = req_q;
  assign bus.Alt_PC           = alt_q;
  assign bus.FLUSH            = flush_q;
  assign bus.fetch_hold       = hold_q;
  assign bus.SYS              = sys_q;
  assign bus.mispredict_count = cnt_q;
  assign bus.state            = state_q;

endmodule

// File: tb/tb_redirect_controller.sv
// Directed bench for redirect_controller: default instance (7/4) plus a
// minimum-depth instance (1/1). Inputs change on the falling edge; outputs
// are sampled on the following falling edge.
module tb_redirect_controller;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  redirect_controller_if bus ();
  redirect_controller_if bus1 ();

  redirect_controller #(.FLUSH_DEPTH(7), .DRAIN_CYCLES(4)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  redirect_controller #(.FLUSH_DEPTH(1), .DRAIN_CYCLES(1)) dut1 (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_bus();
    bus.STALL = 1'b0; bus.pred_take = 1'b0; bus.pred_addr = 32'h0;
    bus.mis_req = 1'b0; bus.mis_addr = 32'h0; bus.sys_req = 1'b0;
    bus.sys_ack = 1'b0; bus.cnt_preload = 1'b0; bus.cnt_preload_val = 16'h0;
  endtask

  task automatic clear_bus1();
    bus1.STALL = 1'b0; bus1.pred_take = 1'b0; bus1.pred_addr = 32'h0;
    bus1.mis_req = 1'b0; bus1.mis_addr = 32'h0; bus1.sys_req = 1'b0;
    bus1.sys_ack = 1'b0; bus1.cnt_preload = 1'b0; bus1.cnt_preload_val = 16'h0;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    clear_bus();
    clear_bus1();
    repeat (2) tick();

    // Reset values
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_req",   32'(bus.Request_Alt_PC), 32'd0);
    chk("rst_alt",   bus.Alt_PC, 32'h0);
    chk("rst_flush", 32'(bus.FLUSH), 32'd0);
    chk("rst_hold",  32'(bus.fetch_hold), 32'd0);
    chk("rst_sys",   32'(bus.SYS), 32'd0);
    chk("rst_cnt",   32'(bus.mispredict_count), 32'd0);
    rst_n = 1'b1;

    // Mispredict with a same-cycle prediction: mis_req wins
    bus.mis_req = 1'b1; bus.mis_addr = 32'h0040_0100;
    bus.pred_take = 1'b1; bus.pred_addr = 32'h0040_0200;
    tick();
    chk("mis_req",   32'(bus.Request_Alt_PC), 32'd1);
    chk("mis_alt",   bus.Alt_PC, 32'h0040_0100);
    chk("mis_flush", 32'(bus.FLUSH), 32'd1);
    chk("mis_cnt",   32'(bus.mispredict_count), 32'd1);
    chk("mis_state", 32'(bus.state), 32'd1);
    chk("mis_hold",  32'(bus.fetch_hold), 32'd0);

    // Requests held during FLUSH are ignored; FLUSH lasts 7 cycles
    bus.mis_addr = 32'h0040_0500; bus.sys_req = 1'b1;
    for (int i = 1; i < 7; i++) begin
      tick();
      chk("flush_state", 32'(bus.state), 32'd1);
      chk("flush_req",   32'(bus.Request_Alt_PC), 32'd0);
      chk("flush_pulse", 32'(bus.FLUSH), 32'd0);
    end
    clear_bus();
    tick();
    chk("flush_done_state", 32'(bus.state), 32'd0);
    chk("flush_done_cnt",   32'(bus.mispredict_count), 32'd1);
    chk("flush_done_alt",   bus.Alt_PC, 32'h0040_0100);

    // Prediction honoured under STALL
    bus.STALL = 1'b1; bus.pred_take = 1'b1; bus.pred_addr = 32'h0040_0200;
    tick();
    chk("pred_req",   32'(bus.Request_Alt_PC), 32'd1);
    chk("pred_alt",   bus.Alt_PC, 32'h0040_0200);
    chk("pred_flush", 32'(bus.FLUSH), 32'd0);
    chk("pred_state", 32'(bus.state), 32'd0);
    clear_bus();
    tick();
    chk("pred_pulse_end", 32'(bus.Request_Alt_PC), 32'd0);
    chk("pred_alt_hold",  bus.Alt_PC, 32'h0040_0200);

    // Stalled mispredict waits for STALL to drop
    bus.STALL = 1'b1; bus.mis_req = 1'b1; bus.mis_addr = 32'h0040_0300;
    tick();
    chk("stall_req",   32'(bus.Request_Alt_PC), 32'd0);
    chk("stall_state", 32'(bus.state), 32'd0);
    chk("stall_cnt",   32'(bus.mispredict_count), 32'd1);
    bus.STALL = 1'b0;
    tick();
    chk("unstall_req",   32'(bus.Request_Alt_PC), 32'd1);
    chk("unstall_alt",   bus.Alt_PC, 32'h0040_0300);
    chk("unstall_flush", 32'(bus.FLUSH), 32'd1);
    chk("unstall_state", 32'(bus.state), 32'd1);
    chk("unstall_cnt",   32'(bus.mispredict_count), 32'd2);
    clear_bus();
    repeat (7) tick();
    chk("unstall_back_run", 32'(bus.state), 32'd0);

    // sys_ack outside SYSWAIT is ignored
    bus.sys_ack = 1'b1;
    tick();
    chk("stray_ack_state", 32'(bus.state), 32'd0);
    chk("stray_ack_sys",   32'(bus.SYS), 32'd0);
    clear_bus();

    // Syscall: same-cycle prediction dropped, 4 drain cycles, then SYSWAIT
    bus.sys_req = 1'b1; bus.pred_take = 1'b1; bus.pred_addr = 32'h0040_0400;
    tick();
    chk("sys_state", 32'(bus.state), 32'd2);
    chk("sys_hold",  32'(bus.fetch_hold), 32'd1);
    chk("sys_req",   32'(bus.Request_Alt_PC), 32'd0);
    chk("sys_sys",   32'(bus.SYS), 32'd0);
    clear_bus();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_state", 32'(bus.state), 32'd2);
    end
    tick();
    chk("syswait_state", 32'(bus.state), 32'd3);
    chk("syswait_sys",   32'(bus.SYS), 32'd1);
    chk("syswait_hold",  32'(bus.fetch_hold), 32'd1);
    repeat (10) tick();
    chk("syswait_long_sys",   32'(bus.SYS), 32'd1);
    chk("syswait_long_state", 32'(bus.state), 32'd3);
    chk("syswait_long_hold",  32'(bus.fetch_hold), 32'd1);
    chk("syswait_alt",        bus.Alt_PC, 32'h0040_0300);
    bus.sys_ack = 1'b1;
    tick();
    chk("ack_sys",   32'(bus.SYS), 32'd0);
    chk("ack_hold",  32'(bus.fetch_hold), 32'd0);
    chk("ack_state", 32'(bus.state), 32'd0);
    clear_bus();

    // Counter saturation
    bus.cnt_preload = 1'b1; bus.cnt_preload_val = 16'hFFFE;
    tick();
    chk("preload_cnt", 32'(bus.mispredict_count), 32'h0000_FFFE);
    clear_bus();
    for (int k = 0; k < 3; k++) begin
      bus.mis_req = 1'b1; bus.mis_addr = 32'h0040_0600;
      tick();
      clear_bus();
      chk("sat_cnt", 32'(bus.mispredict_count), 32'h0000_FFFF);
      repeat (7) tick();
    end
    chk("sat_state", 32'(bus.state), 32'd0);

    // Asynchronous reset in SYSWAIT
    bus.sys_req = 1'b1;
    tick();
    clear_bus();
    repeat (4) tick();
    chk("pre_rst_sys", 32'(bus.SYS), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sys",   32'(bus.SYS), 32'd0);
    chk("async_rst_cnt",   32'(bus.mispredict_count), 32'd0);
    chk("async_rst_state", 32'(bus.state), 32'd0);
    chk("async_rst_hold",  32'(bus.fetch_hold), 32'd0);
    chk("async_rst_alt",   bus.Alt_PC, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_req",   32'(bus.Request_Alt_PC), 32'd0);
    chk("post_rst_flush", 32'(bus.FLUSH), 32'd0);
    chk("post_rst_sys",   32'(bus.SYS), 32'd0);
    chk("post_rst_state", 32'(bus.state), 32'd0);

    // Depth-1 instance: FLUSH and DRAIN last exactly one cycle
    bus1.mis_req = 1'b1; bus1.mis_addr = 32'h0040_0700;
    tick();
    clear_bus1();
    chk("d1_flush_state", 32'(bus1.state), 32'd1);
    chk("d1_flush_alt",   bus1.Alt_PC, 32'h0040_0700);
    tick();
    chk("d1_run_state", 32'(bus1.state), 32'd0);
    chk("d1_run_req",   32'(bus1.Request_Alt_PC), 32'd0);
    bus1.sys_req = 1'b1;
    tick();
    clear_bus1();
    chk("d1_drain_state", 32'(bus1.state), 32'd2);
    tick();
    chk("d1_syswait_state", 32'(bus1.state), 32'd3);
    chk("d1_syswait_sys",   32'(bus1.SYS), 32'd1);
    bus1.sys_ack = 1'b1;
    tick();
    clear_bus1();
    chk("d1_ack_state", 32'(bus1.state), 32'd0);
    chk("d1_ack_sys",   32'(bus1.SYS), 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/redirect_controller.md
REDIRECT_CONTROLLER -- requirements
Module: redirect_controller

Interface
REQ-001 Parameter FLUSH_DEPTH, default 7: cycles of wrong-path suppression after a redirect, equal to the fetch-buffer stages between IF and ID.
REQ-002 Parameter DRAIN_CYCLES, default 4: cycles for the ID/EXE/MEM/WB stages to retire before a syscall handoff.
REQ-003 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 STALL  in  1  ID freeze; when 1, ID-originated requests are not sampled.
REQ-006 pred_take  in  1  predictor requests a taken fetch redirect.
REQ-007 pred_addr  in  32  predicted target.
REQ-008 mis_req  in  1  ID resolution reports a misprediction.
REQ-009 mis_addr  in  32  corrected PC.
REQ-010 sys_req  in  1  syscall decoded in ID.
REQ-011 sys_ack  in  1  simulator finished syscall service.
REQ-012 Request_Alt_PC  out  1  registered redirect strobe to IF.
REQ-013 Alt_PC  out  32  registered redirect target.
REQ-014 FLUSH  out  1  one-cycle clear of all fetch-buffer stages.
REQ-015 fetch_hold  out  1  freezes IF PC.
REQ-016 SYS  out  1  pipeline drained, syscall may proceed.
REQ-017 mispredict_count  out  16  saturating mispredict counter.
REQ-018 state  out  2  RUN=0, FLUSH=1, DRAIN=2, SYSWAIT=3.

Function
REQ-019 All outputs SHALL be registered, with a latency of 1 cycle from the sampled input to the output.
REQ-020 In RUN with STALL=0, mis_req SHALL have priority over sys_req and pred_take.
- Next cycle: Request_Alt_PC=1, Alt_PC=mis_addr, FLUSH=1.
- mispredict_count increments.
- Next state is FLUSH, with the counter loaded to FLUSH_DEPTH-1.
REQ-021 In RUN, pred_take without mis_req or sys_req SHALL produce Request_Alt_PC=1 and Alt_PC=pred_addr next cycle, with FLUSH=0 and no state change.
REQ-022 pred_take SHALL be honoured regardless of STALL.
REQ-023 In RUN with STALL=0, sys_req without mis_req SHALL enter DRAIN.
- fetch_hold=1.
- Counter loaded to DRAIN_CYCLES-1.
- A pred_take in the same cycle is dropped.
REQ-024 Request_Alt_PC and FLUSH SHALL be single-cycle pulses; outside pulse cycles Alt_PC holds its last value.
REQ-025 In FLUSH, mis_req, sys_req and pred_take SHALL be ignored.
- The counter decrements every cycle, independent of STALL.
- Return to RUN the cycle after the counter reaches 0.
REQ-026 In DRAIN, fetch_hold=1 and all requests SHALL be ignored.
- The counter decrements every cycle.
- At 0, go to SYSWAIT with SYS=1.
REQ-027 In SYSWAIT, SYS and fetch_hold SHALL stay 1 until sys_ack=1.
- Next cycle: SYS=0, fetch_hold=0, state RUN.
- sys_ack in any other state is ignored.
REQ-028 mispredict_count SHALL saturate at 0xFFFF and never wrap.
REQ-029 With FLUSH_DEPTH=1 or DRAIN_CYCLES=1, the state SHALL occupy exactly one cycle before advancing.

Reset
REQ-030 RESET=0 SHALL immediately, without waiting for CLK, force:
- state=RUN, counter=0.
- Request_Alt_PC=0, Alt_PC=0x00000000, FLUSH=0.
- fetch_hold=0, SYS=0, mispredict_count=0.
REQ-031 Reset asserted mid-FLUSH, mid-DRAIN or in SYSWAIT SHALL abort the sequence, with no residual pulse after release.
REQ-032 The first request SHALL be sampled on the first rising CLK edge with RESET=1.

Verification
REQ-033 mis_req=1, mis_addr=0x00400100, STALL=0 in RUN -> next cycle:
- Request_Alt_PC=1, Alt_PC=0x00400100, FLUSH=1, count=1.
- state=FLUSH for 7 cycles, then RUN.
REQ-034 mis_req=1 and pred_take=1 (pred_addr=0x00400200) in the same cycle -> Alt_PC=0x00400100 only; pred_take is dropped.
REQ-035 pred_take=1 during FLUSH -> no Request_Alt_PC pulse.
REQ-036 mis_req=1 with STALL=1 -> no response; STALL drops to 0 with mis_req held -> redirect next cycle.
REQ-037 sys_req=1 in RUN:
- fetch_hold=1, DRAIN for 4 cycles, then SYS=1.
- SYS=1 held across a 10-cycle wait.
- sys_ack=1 -> SYS=0, fetch_hold=0, RUN.
REQ-038 Counter saturation and reset:
- Preload mispredict_count to 0xFFFE, apply 3 mispredicts -> count=0xFFFF.
- RESET=0 in SYSWAIT -> SYS=0 and count=0 without a clock edge.
